// File: rtl/instr_fetch.sv
// 6502 instruction fetch front end: reads opcode plus 0-2 operand bytes, hands them to the decoder.
// Optional VECTOR_FETCH_EN: load the start PC from the reset vector at FFFC/FFFD instead of RESET_PC.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

module instr_fetch #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int REG_WIDTH  = `REG_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(16'h8000)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_rd,
  input  logic [REG_WIDTH-1:0]   mem_rdata,
  input  logic                   mem_valid,
  output logic [REG_WIDTH-1:0]   instruction_out,
  output logic [2*REG_WIDTH-1:0] operand,
  output logic [1:0]             instr_len,
  output logic                   instruction_ready,
  input  logic                   instruction_done,
  input  logic                   pc_load,
  input  logic [ADDR_WIDTH-1:0]  pc_load_value,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   illegal
);

  typedef enum logic [2:0] {
    S_OP,
    S_LO,
    S_HI,
    S_READY,
    S_VEC_LO,
    S_VEC_HI
  } state_t;

`ifdef VECTOR_FETCH_EN
  localparam state_t START_STATE = S_VEC_LO;
  localparam logic [ADDR_WIDTH-1:0] VEC_LO_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] VEC_HI_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b01};
`else
  localparam state_t START_STATE = S_OP;
`endif

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    pc_q;
  logic [REG_WIDTH-1:0]     opcode_p0;
  logic [2*REG_WIDTH-1:0]   operand_p0;
  logic [1:0]               len_p0;
  logic                     armed_q;
  logic                     fetch_rd;
  logic [ADDR_WIDTH-1:0]    fetch_addr;
  logic                     ready_c;
  logic                     accept;
  logic                     done_take;
`ifdef VECTOR_FETCH_EN
  logic [REG_WIDTH-1:0]     vec_lo_p0;
`endif

  // 6502 instruction length from the cc/bbb fields of the opcode
  function automatic logic [1:0] len_decode(input logic [REG_WIDTH-1:0] op);
    logic [2:0] bbb;
    logic [1:0] len;
    bbb = op[4:2];
    len = 2'd1;
    case (op[1:0])
      2'b01: len = (bbb inside {3'd3, 3'd6, 3'd7}) ? 2'd3 : 2'd2;
      2'b10: begin
        case (bbb)
          3'd3, 3'd7:       len = 2'd3;
          3'd0, 3'd1, 3'd5: len = 2'd2;
          default:          len = 2'd1;
        endcase
      end
      2'b00: begin
        case (bbb)
          3'd3, 3'd7:       len = 2'd3;
          3'd1, 3'd4, 3'd5: len = 2'd2;
          3'd2, 3'd6:       len = 2'd1;
          default: begin
            if (op == REG_WIDTH'(8'h20))
              len = 2'd3;
            else if (op == REG_WIDTH'(8'h00) || op == REG_WIDTH'(8'h40) ||
                     op == REG_WIDTH'(8'h60))
              len = 2'd1;
            else
              len = 2'd2;
          end
        endcase
      end
      default: len = 2'd1;
    endcase
    return len;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= START_STATE;
    else
      state_q <= state_d;
  end

  always_comb begin
    fetch_rd   = 1'b0;
    fetch_addr = '0;
    ready_c    = 1'b0;
    state_d    = state_q;
    case (state_q)
      S_OP, S_LO, S_HI: begin
        fetch_rd   = 1'b1;
        fetch_addr = pc_q;
      end
`ifdef VECTOR_FETCH_EN
      S_VEC_LO: begin
        fetch_rd   = 1'b1;
        fetch_addr = VEC_LO_ADDR;
      end
      S_VEC_HI: begin
        fetch_rd   = 1'b1;
        fetch_addr = VEC_HI_ADDR;
      end
`endif
      S_READY: ready_c = 1'b1;
      default: ;
    endcase

    accept    = fetch_rd && mem_valid && !reset;
    // done is stale on the first READY cycle, so only honour it once armed
    done_take = (state_q == S_READY) && armed_q && instruction_done;

    case (state_q)
      S_OP:     if (accept) state_d = (len_decode(mem_rdata) >= 2'd2) ? S_LO : S_READY;
      S_LO:     if (accept) state_d = (len_p0 == 2'd3) ? S_HI : S_READY;
      S_HI:     if (accept) state_d = S_READY;
      S_READY:  if (done_take) state_d = S_OP;
`ifdef VECTOR_FETCH_EN
      S_VEC_LO: if (accept) state_d = S_VEC_HI;
      S_VEC_HI: if (accept) state_d = S_OP;
`endif
      default:  state_d = S_OP;
    endcase
  end

  // Fetched instruction fields and program counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      opcode_p0  <= '0;
      operand_p0 <= '0;
      len_p0     <= '0;
      armed_q    <= 1'b0;
`ifdef VECTOR_FETCH_EN
      vec_lo_p0  <= '0;
`endif
    end else begin
      armed_q <= (state_q == S_READY) && (state_d == S_READY);
      case (state_q)
        S_OP: begin
          if (accept) begin
            opcode_p0  <= mem_rdata;
            len_p0     <= len_decode(mem_rdata);
            operand_p0 <= '0;
            pc_q       <= pc_q + ADDR_WIDTH'(1);
          end
        end
        S_LO: begin
          if (accept) begin
            operand_p0[REG_WIDTH-1:0] <= mem_rdata;
            pc_q                      <= pc_q + ADDR_WIDTH'(1);
          end
        end
        S_HI: begin
          if (accept) begin
            operand_p0[2*REG_WIDTH-1:REG_WIDTH] <= mem_rdata;
            pc_q                                <= pc_q + ADDR_WIDTH'(1);
          end
        end
        S_READY: begin
          if (done_take && pc_load)
            pc_q <= pc_load_value;
        end
`ifdef VECTOR_FETCH_EN
        S_VEC_LO: if (accept) vec_lo_p0 <= mem_rdata;
        S_VEC_HI: if (accept) pc_q <= ADDR_WIDTH'({mem_rdata, vec_lo_p0});
`endif
        default: ;
      endcase
    end
  end

  assign mem_rd            = fetch_rd && !reset;
  assign mem_addr          = reset ? '0 : fetch_addr;
  assign instruction_ready = ready_c && !reset;
  assign instruction_out   = opcode_p0;
  assign operand           = operand_p0;
  assign instr_len         = len_p0;
  assign pc                = pc_q;
  assign illegal           = ready_c && !reset && (opcode_p0[1:0] == 2'b11);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory responder with programmable wait states, decoder handshake stimulus.
module tb_instr_fetch;

  localparam logic [15:0] RST_PC = 16'h8000;
`ifdef VECTOR_FETCH_EN
  localparam logic [15:0] BASE    = 16'h9000;
  localparam logic [15:0] START_A = 16'hFFFC;
  localparam int          VN      = 2;
`else
  localparam logic [15:0] BASE    = 16'h8000;
  localparam logic [15:0] START_A = 16'h8000;
  localparam int          VN      = 0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_valid;
  logic [7:0]  instruction_out;
  logic [15:0] operand;
  logic [1:0]  instr_len;
  logic        instruction_ready;
  logic        instruction_done;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [15:0] pc;
  logic        illegal;

  logic [7:0]  mem [0:65535];
  logic [15:0] acc_q [$];
  int          n_cmp;
  int          n_fail;
  int          latency;
  int          wcnt;
  bit          resp_en;

  instr_fetch #(.ADDR_WIDTH(16), .REG_WIDTH(8), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .instruction_out(instruction_out),
    .operand(operand), .instr_len(instr_len), .instruction_ready(instruction_ready),
    .instruction_done(instruction_done), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .pc(pc), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: data appears after `latency` idle cycles of a held request
  always begin
    @(negedge clk);
    #2;
    if (resp_en) begin
      if (mem_valid) begin
        mem_valid = 1'b0;
        wcnt = 0;
      end
      if (mem_rd) begin
        if (wcnt >= latency) begin
          mem_valid = 1'b1;
          mem_rdata = mem[mem_addr];
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (mem_rd && mem_valid) acc_q.push_back(mem_addr);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    instruction_done = 1'b0;
    pc_load = 1'b0;
    repeat (2) @(negedge clk);
    acc_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (instruction_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    instruction_done = 1'b0;
    pc_load = 1'b0;
    pc_load_value = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (pc !== RST_PC) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc, RST_PC); end
    n_cmp++; if (instruction_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", instruction_ready); end
    n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
    n_cmp++; if (instruction_out !== 8'h00) begin n_fail++; $display("FAIL rst_opcode: got %h want 00", instruction_out); end
    n_cmp++; if (operand !== 16'h0000) begin n_fail++; $display("FAIL rst_operand: got %h want 0000", operand); end
    n_cmp++; if (instr_len !== 2'd0) begin n_fail++; $display("FAIL rst_len: got %0d want 0", instr_len); end
    n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal: got %b want 0", illegal); end
  endtask

  task automatic test_zero_wait();
    logic ok;
    latency = 0;
    mem[BASE] = 8'hA9; mem[BASE + 16'd1] = 8'h42; mem[BASE + 16'd2] = 8'hEA;
    do_reset();
    wait_ready(40, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zw_ready_rise: got %b want 1", ok); end
    n_cmp++; if (acc_q.size() != VN + 2) begin n_fail++; $display("FAIL zw_accepts: got %0d want %0d", acc_q.size(), VN + 2); end
    n_cmp++; if (instruction_out !== 8'hA9) begin n_fail++; $display("FAIL zw_opcode: got %h want a9", instruction_out); end
    n_cmp++; if (operand !== 16'h0042) begin n_fail++; $display("FAIL zw_operand: got %h want 0042", operand); end
    n_cmp++; if (instr_len !== 2'd2) begin n_fail++; $display("FAIL zw_len: got %0d want 2", instr_len); end
    n_cmp++; if (pc !== BASE + 16'd2) begin n_fail++; $display("FAIL zw_pc: got %h want %h", pc, BASE + 16'd2); end
    @(negedge clk);
    instruction_done = 1'b1;
    @(negedge clk);
    instruction_done = 1'b0;
    #1;
    n_cmp++; if (instruction_ready !== 1'b0) begin n_fail++; $display("FAIL zw_ready_drop: got %b want 0", instruction_ready); end
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== BASE + 16'd2) begin n_fail++; $display("FAIL zw_next_fetch: got rd=%b addr=%h want rd=1 addr=%h", mem_rd, mem_addr, BASE + 16'd2); end
  endtask

  task automatic test_wait_states();
    logic ok;
    int   hold_bad;
    int   cyc;
    latency = 3;
    mem[BASE] = 8'h8D; mem[BASE + 16'd1] = 8'h34; mem[BASE + 16'd2] = 8'h12;
    do_reset();
    ok = 1'b0; hold_bad = 0; cyc = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      cyc++;
      if (instruction_ready) begin
        ok = 1'b1;
        break;
      end
      if (mem_rd && acc_q.size() >= VN && mem_addr !== BASE + 16'(acc_q.size() - VN)) hold_bad++;
    end
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ws_ready_rise: got %b want 1", ok); end
    n_cmp++; if (hold_bad != 0) begin n_fail++; $display("FAIL ws_addr_hold: got %0d bad cycles want 0", hold_bad); end
    n_cmp++; if (cyc != 12 + 4 * VN) begin n_fail++; $display("FAIL ws_latency: got %0d cycles want %0d", cyc, 12 + 4 * VN); end
    n_cmp++; if (acc_q.size() != VN + 3) begin n_fail++; $display("FAIL ws_accepts: got %0d want %0d", acc_q.size(), VN + 3); end
    n_cmp++; if (operand !== 16'h1234) begin n_fail++; $display("FAIL ws_operand: got %h want 1234", operand); end
    n_cmp++; if (instr_len !== 2'd3) begin n_fail++; $display("FAIL ws_len: got %0d want 3", instr_len); end
    n_cmp++; if (pc !== BASE + 16'd3) begin n_fail++; $display("FAIL ws_pc: got %h want %h", pc, BASE + 16'd3); end
  endtask

  task automatic test_done_held();
    logic ok;
    int   hi;
    latency = 0;
    mem[BASE] = 8'hA9; mem[BASE + 16'd1] = 8'h42;
    mem[BASE + 16'd2] = 8'h8D; mem[BASE + 16'd3] = 8'h34; mem[BASE + 16'd4] = 8'h12;
    do_reset();
    wait_ready(40, ok);
    instruction_done = 1'b1;
    hi = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (instruction_ready) hi++;
      else break;
    end
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL dh_ready_rise: got %b want 1", ok); end
    n_cmp++; if (hi != 2) begin n_fail++; $display("FAIL dh_ready_width: got %0d cycles want 2", hi); end
    wait_ready(40, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL dh_second_ready: got %b want 1", ok); end
    n_cmp++; if (instruction_out !== 8'h8D) begin n_fail++; $display("FAIL dh_no_skip: got %h want 8d", instruction_out); end
    n_cmp++; if (acc_q[VN + 2] !== BASE + 16'd2) begin n_fail++; $display("FAIL dh_next_addr: got %h want %h", acc_q[VN + 2], BASE + 16'd2); end
    n_cmp++; if (operand !== 16'h1234 || pc !== BASE + 16'd5) begin n_fail++; $display("FAIL dh_second_instr: got op=%h pc=%h want op=1234 pc=%h", operand, pc, BASE + 16'd5); end
    instruction_done = 1'b0;
  endtask

  task automatic test_pc_load();
    logic ok;
    latency = 0;
    mem[BASE] = 8'hA9; mem[BASE + 16'd1] = 8'h42;
    do_reset();
    pc_load = 1'b1;
    pc_load_value = 16'h4444;
    wait_ready(40, ok);
    pc_load = 1'b0;
    n_cmp++; if (ok !== 1'b1 || pc !== BASE + 16'd2) begin n_fail++; $display("FAIL pl_ignored_in_fetch: got ok=%b pc=%h want ok=1 pc=%h", ok, pc, BASE + 16'd2); end
    n_cmp++; if (acc_q[VN + 1] !== BASE + 16'd1) begin n_fail++; $display("FAIL pl_operand_addr: got %h want %h", acc_q[VN + 1], BASE + 16'd1); end
    @(negedge clk);
    #1;
    n_cmp++; if (instruction_ready !== 1'b1 || operand !== 16'h0042) begin n_fail++; $display("FAIL pl_ready_stable: got rdy=%b op=%h want rdy=1 op=0042", instruction_ready, operand); end
    instruction_done = 1'b1;
    pc_load = 1'b1;
    pc_load_value = 16'hC000;
    @(negedge clk);
    instruction_done = 1'b0;
    pc_load = 1'b0;
    #1;
    n_cmp++; if (mem_addr !== 16'hC000) begin n_fail++; $display("FAIL pl_redirect_addr: got %h want c000", mem_addr); end
    n_cmp++; if (pc !== 16'hC000) begin n_fail++; $display("FAIL pl_redirect_pc: got %h want c000", pc); end
  endtask

  task automatic test_wrap();
    logic ok;
    latency = 0;
    mem[BASE] = 8'hA9; mem[BASE + 16'd1] = 8'h42;
    mem[16'hFFFF] = 8'hEA; mem[16'h0000] = 8'h03; mem[16'h0001] = 8'hEA;
    do_reset();
    wait_ready(40, ok);
    @(negedge clk);
    instruction_done = 1'b1;
    pc_load = 1'b1;
    pc_load_value = 16'hFFFF;
    @(negedge clk);
    instruction_done = 1'b0;
    pc_load = 1'b0;
    wait_ready(40, ok);
    n_cmp++; if (ok !== 1'b1 || acc_q[$] !== 16'hFFFF) begin n_fail++; $display("FAIL wr_fetch_ffff: got ok=%b addr=%h want ok=1 addr=ffff", ok, acc_q[$]); end
    n_cmp++; if (instruction_out !== 8'hEA || instr_len !== 2'd1) begin n_fail++; $display("FAIL wr_nop: got op=%h len=%0d want op=ea len=1", instruction_out, instr_len); end
    n_cmp++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wr_pc_wrap: got %h want 0000", pc); end
    n_cmp++; if (operand !== 16'h0000 || illegal !== 1'b0) begin n_fail++; $display("FAIL wr_nop_fields: got op=%h ill=%b want op=0000 ill=0", operand, illegal); end
    @(negedge clk);
    instruction_done = 1'b1;
    @(negedge clk);
    instruction_done = 1'b0;
    #1;
    n_cmp++; if (mem_addr !== 16'h0000 || mem_rd !== 1'b1) begin n_fail++; $display("FAIL wr_next_fetch: got rd=%b addr=%h want rd=1 addr=0000", mem_rd, mem_addr); end
    wait_ready(40, ok);
    n_cmp++; if (instruction_out !== 8'h03 || illegal !== 1'b1) begin n_fail++; $display("FAIL wr_illegal: got op=%h ill=%b want op=03 ill=1", instruction_out, illegal); end
    n_cmp++; if (instr_len !== 2'd1 || pc !== 16'h0001) begin n_fail++; $display("FAIL wr_illegal_len: got len=%0d pc=%h want len=1 pc=0001", instr_len, pc); end
    @(negedge clk);
    instruction_done = 1'b1;
    @(negedge clk);
    instruction_done = 1'b0;
    #1;
    n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL wr_illegal_clear: got %b want 0", illegal); end
  endtask

  task automatic test_reset_mid();
    logic found;
    latency = 10;
    mem[BASE] = 8'h8D; mem[BASE + 16'd1] = 8'h34; mem[BASE + 16'd2] = 8'h12;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (mem_rd && mem_addr === BASE + 16'd1) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL rm_reach_lo: got %b want 1", found); end
    resp_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_rdata = 8'h34;
    #1;
    n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rm_rd_in_reset: got %b want 0", mem_rd); end
    @(negedge clk);
    mem_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++; if (pc !== RST_PC) begin n_fail++; $display("FAIL rm_pc: got %h want %h", pc, RST_PC); end
    n_cmp++; if (instruction_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready: got %b want 0", instruction_ready); end
    n_cmp++; if (operand !== 16'h0000 || instruction_out !== 8'h00) begin n_fail++; $display("FAIL rm_data_ignored: got op=%h opc=%h want 0000 00", operand, instruction_out); end
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== START_A) begin n_fail++; $display("FAIL rm_restart: got rd=%b addr=%h want rd=1 addr=%h", mem_rd, mem_addr, START_A); end
    wcnt = 0;
    resp_en = 1'b1;
  endtask

`ifdef VECTOR_FETCH_EN
  task automatic test_vector();
    logic ok;
    latency = 0;
    mem[16'h9000] = 8'hA9; mem[16'h9001] = 8'h42;
    do_reset();
    wait_ready(40, ok);
    n_cmp++; if (acc_q[0] !== 16'hFFFC || acc_q[1] !== 16'hFFFD) begin n_fail++; $display("FAIL vec_reads: got %h %h want fffc fffd", acc_q[0], acc_q[1]); end
    n_cmp++; if (acc_q[2] !== 16'h9000) begin n_fail++; $display("FAIL vec_first_opcode: got %h want 9000", acc_q[2]); end
    n_cmp++; if (ok !== 1'b1 || pc !== 16'h9002) begin n_fail++; $display("FAIL vec_pc: got ok=%b pc=%h want ok=1 pc=9002", ok, pc); end
  endtask
`endif

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; instruction_done = 1'b0; pc_load = 1'b0; pc_load_value = 16'h0000;
    mem_valid = 1'b0; mem_rdata = 8'h00; latency = 0; wcnt = 0; resp_en = 1'b1;
    for (int a = 0; a < 65536; a++) mem[a] = 8'hEA;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h90;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_done_held();
    test_pc_load();
    test_wrap();
    test_reset_mid();
`ifdef VECTOR_FETCH_EN
    test_vector();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
